// File: rtl/core_pkg.sv
// Shared vector-unit types: instruction IDs, functional-unit selector and the
// issue request that travels from decode through the launcher to the scoreboard.
package core_pkg;

  localparam int unsigned NrVFU     = 4;
  localparam int unsigned InsnIDNum = 8;
  localparam int unsigned InsnIDW   = $clog2(InsnIDNum);

  typedef logic [InsnIDW-1:0] insn_id_t;

  // One encoding bit wider than NrVFU needs, so an out-of-range target is representable
  typedef enum logic [2:0] {
    VFU_ALU = 3'd0,
    VFU_MUL = 3'd1,
    VFU_LSU = 3'd2,
    VFU_SLD = 3'd3
  } vfu_e;

  localparam int unsigned VfuW = $bits(vfu_e);

  typedef struct packed {
    logic [7:0] op;
    logic [4:0] vd;
    logic [4:0] vs1;
    vfu_e       vfu;
    insn_id_t   insn_id;
  } issue_req_t;

endpackage

// File: rtl/insn_id_alloc.sv
// In-flight instruction ID pool: busy bitmap with lowest-free selection,
// one allocation per cycle and up to one release per functional unit.
module insn_id_alloc
  import core_pkg::*;
#(
  parameter int unsigned NumIds = InsnIDNum,
  parameter int unsigned NrFree = NrVFU
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_i,
  input  logic     [NrFree-1:0] free_i,
  input  insn_id_t [NrFree-1:0] free_id_i,
  output insn_id_t              id_o,
  output logic                  avail_o,
  output logic                  all_free_o
);

  logic [NumIds-1:0] busy_q;
  logic [NumIds-1:0] busy_d;

  // Scan downward so the lowest clear index is the one left standing
  always_comb begin
    id_o = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (!busy_q[i]) id_o = insn_id_t'(i);
    end
  end

  assign avail_o    = ~&busy_q;
  assign all_free_o = ~|busy_q;

  always_comb begin
    busy_d = busy_q;
    if (alloc_i) busy_d[id_o] = 1'b1;
    for (int i = 0; i < int'(NrFree); i++) begin
      if (free_i[i]) busy_d[free_id_i[i]] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  for (genvar g = 0; g < int'(NrFree); g++) begin : g_free_chk
    a_free_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
      free_i[g] |-> busy_q[free_id_i[g]]);
  end

  a_alloc_avail : assert property (@(posedge clk_i) disable iff (!rst_ni)
    alloc_i |-> avail_o);

endmodule

// File: rtl/insn_launcher.sv
// Vector issue stage: single holding register that tags the head instruction
// with a free ID, waits out scoreboard hazards and dispatches to its VFU.
module insn_launcher
  import core_pkg::*;
#(
  parameter int unsigned NrVFU     = core_pkg::NrVFU,
  parameter int unsigned InsnIDNum = core_pkg::InsnIDNum
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dec_valid_i,
  output logic                 dec_ready_o,
  input  issue_req_t           dec_req_i,
  output issue_req_t           sb_req_o,
  input  logic                 sb_stall_i,
  output logic                 sb_issued_o,
  output logic     [NrVFU-1:0] vfu_valid_o,
  input  logic     [NrVFU-1:0] vfu_ready_i,
  output issue_req_t           vfu_req_o,
  input  logic     [NrVFU-1:0] insn_done_i,
  input  insn_id_t [NrVFU-1:0] insn_done_id_i,
  output logic                 idle_o
);

  logic             hold_valid_q;
  issue_req_t       hold_req_q;
  issue_req_t       tagged_req;
  insn_id_t         free_id;
  logic             id_avail;
  logic             all_free;
  logic             can_go;
  logic             fire;
  logic             load;
  logic [NrVFU-1:0] tgt_sel;
  logic [VfuW-1:0]  tgt_idx;

  insn_id_alloc #(
    .NumIds (InsnIDNum),
    .NrFree (NrVFU)
  ) u_id_alloc (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .alloc_i    (fire),
    .free_i     (insn_done_i),
    .free_id_i  (insn_done_id_i),
    .id_o       (free_id),
    .avail_o    (id_avail),
    .all_free_o (all_free)
  );

  always_comb begin
    tagged_req         = hold_req_q;
    tagged_req.insn_id = free_id;
  end

  assign sb_req_o  = tagged_req;
  assign vfu_req_o = tagged_req;

  // One-hot target decode; an out-of-range vfu selects nothing
  assign tgt_idx = hold_req_q.vfu;
  always_comb begin
    tgt_sel = '0;
    for (int i = 0; i < int'(NrVFU); i++) begin
      tgt_sel[i] = (tgt_idx == VfuW'(i));
    end
  end

  assign can_go      = hold_valid_q & ~sb_stall_i & id_avail;
  assign vfu_valid_o = {NrVFU{can_go}} & tgt_sel;
  assign fire        = can_go & |(vfu_ready_i & tgt_sel);
  assign sb_issued_o = fire;

  assign dec_ready_o = ~hold_valid_q | fire;
  assign load        = dec_valid_i & dec_ready_o;
  assign idle_o      = ~hold_valid_q & all_free;

  // Holding register: control is reset, payload only loads
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   hold_valid_q <= 1'b0;
    else if (load) hold_valid_q <= 1'b1;
    else if (fire) hold_valid_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (load) hold_req_q <= dec_req_i;
  end

  a_vfu_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    hold_valid_q |-> (32'(tgt_idx) < NrVFU));

  a_payload_frozen : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (hold_valid_q && !fire) |=> $stable(hold_req_q));

endmodule

// File: tb/tb_insn_launcher.sv
// Directed bench for insn_launcher: reset, single issue, back-to-back issue,
// stall, VFU backpressure, ID exhaustion/recycle and async reset mid-operation.
module tb_insn_launcher;
  import core_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 dec_valid_i;
  logic                 dec_ready_o;
  issue_req_t           dec_req_i;
  issue_req_t           sb_req_o;
  logic                 sb_stall_i;
  logic                 sb_issued_o;
  logic     [NrVFU-1:0] vfu_valid_o;
  logic     [NrVFU-1:0] vfu_ready_i;
  issue_req_t           vfu_req_o;
  logic     [NrVFU-1:0] insn_done_i;
  insn_id_t [NrVFU-1:0] insn_done_id_i;
  logic                 idle_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  insn_launcher dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .dec_valid_i    (dec_valid_i),
    .dec_ready_o    (dec_ready_o),
    .dec_req_i      (dec_req_i),
    .sb_req_o       (sb_req_o),
    .sb_stall_i     (sb_stall_i),
    .sb_issued_o    (sb_issued_o),
    .vfu_valid_o    (vfu_valid_o),
    .vfu_ready_i    (vfu_ready_i),
    .vfu_req_o      (vfu_req_o),
    .insn_done_i    (insn_done_i),
    .insn_done_id_i (insn_done_id_i),
    .idle_o         (idle_o)
  );

  function automatic issue_req_t mk(input logic [2:0] v, input logic [7:0] op,
                                    input logic [4:0] vd, input logic [2:0] id);
    issue_req_t r;
    r.op      = op;
    r.vd      = vd;
    r.vs1     = 5'(vd + 5'd1);
    r.vfu     = vfu_e'(v);
    r.insn_id = insn_id_t'(id);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni         = 1'b0;
    dec_valid_i    = 1'b0;
    dec_req_i      = '0;
    sb_stall_i     = 1'b0;
    vfu_ready_i    = '1;
    insn_done_i    = '0;
    insn_done_id_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_dec_ready", 32'(dec_ready_o), 1);
    chk("rst_vfu_valid", 32'(vfu_valid_o), 0);
    chk("rst_issued", 32'(sb_issued_o), 0);
    chk("rst_idle", 32'(idle_o), 1);
    rst_ni = 1'b1;

    // Single request to VFU 1; decode-side insn_id is ignored
    dec_valid_i = 1'b1;
    dec_req_i   = mk(3'd1, 8'hA5, 5'd1, 3'd7);
    #1;
    chk("t1_dec_ready", 32'(dec_ready_o), 1);
    edge1;
    dec_valid_i = 1'b0;
    #1;
    chk("t1_valid", 32'(vfu_valid_o), 32'b0010);
    chk("t1_issued", 32'(sb_issued_o), 1);
    chk("t1_id", 32'(sb_req_o.insn_id), 0);
    chk("t1_payload", 32'(sb_req_o), 32'(mk(3'd1, 8'hA5, 5'd1, 3'd0)));
    chk("t1_bcast", 32'(vfu_req_o), 32'(mk(3'd1, 8'hA5, 5'd1, 3'd0)));
    chk("t1_idle_held", 32'(idle_o), 0);
    edge1;
    chk("t1_after_issued", 32'(sb_issued_o), 0);
    chk("t1_idle_busy", 32'(idle_o), 0);
    insn_done_i       = 4'b0010;
    insn_done_id_i[1] = 3'd0;
    #1;
    chk("t1_idle_done_cycle", 32'(idle_o), 0);
    edge1;
    insn_done_i = '0;
    #1;
    chk("t1_idle_after", 32'(idle_o), 1);

    // Four back-to-back requests, one per VFU
    dec_valid_i = 1'b1;
    dec_req_i   = mk(3'd0, 8'h10, 5'd0, 3'd0);
    edge1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) dec_req_i = mk(3'(i + 1), 8'(16 + i + 1), 5'(i + 1), 3'd0);
      else       dec_valid_i = 1'b0;
      #1;
      chk("t2_issued", 32'(sb_issued_o), 1);
      chk("t2_id", 32'(sb_req_o.insn_id), 32'(i));
      chk("t2_valid", 32'(vfu_valid_o), 32'(1) << i);
      chk("t2_dec_ready", 32'(dec_ready_o), 1);
      edge1;
    end
    #1;
    chk("t2_drained", 32'(sb_issued_o), 0);
    insn_done_i = '1;
    for (int i = 0; i < 4; i++) insn_done_id_i[i] = 3'(i);
    edge1;
    insn_done_i = '0;
    #1;
    chk("t2_idle", 32'(idle_o), 1);

    // Stall a held request for 5 cycles while a younger one waits
    sb_stall_i  = 1'b1;
    dec_valid_i = 1'b1;
    dec_req_i   = mk(3'd2, 8'h3C, 5'd5, 3'd0);
    edge1;
    dec_req_i = mk(3'd3, 8'h77, 5'd9, 3'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_valid", 32'(vfu_valid_o), 0);
      chk("t3_dec_ready", 32'(dec_ready_o), 0);
      chk("t3_issued", 32'(sb_issued_o), 0);
      chk("t3_payload", 32'(sb_req_o), 32'(mk(3'd2, 8'h3C, 5'd5, 3'd0)));
      edge1;
    end
    sb_stall_i = 1'b0;
    #1;
    chk("t3_fire", 32'(sb_issued_o), 1);
    chk("t3_fire_valid", 32'(vfu_valid_o), 32'b0100);
    chk("t3_fire_id", 32'(sb_req_o.insn_id), 0);
    chk("t3_fire_ready", 32'(dec_ready_o), 1);
    edge1;

    // Target VFU 3 not ready for 3 cycles
    dec_valid_i = 1'b0;
    vfu_ready_i = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_valid", 32'(vfu_valid_o), 32'b1000);
      chk("t4_issued", 32'(sb_issued_o), 0);
      chk("t4_payload", 32'(sb_req_o), 32'(mk(3'd3, 8'h77, 5'd9, 3'd1)));
      edge1;
    end
    vfu_ready_i = '1;
    #1;
    chk("t4_fire", 32'(sb_issued_o), 1);
    chk("t4_id", 32'(sb_req_o.insn_id), 1);
    edge1;
    insn_done_i       = 4'b1100;
    insn_done_id_i[2] = 3'd0;
    insn_done_id_i[3] = 3'd1;
    edge1;
    insn_done_i = '0;
    #1;
    chk("t4_idle", 32'(idle_o), 1);

    // Exhaust all IDs; the ninth request holds
    dec_valid_i = 1'b1;
    dec_req_i   = mk(3'd0, 8'h40, 5'd0, 3'd0);
    edge1;
    for (int i = 0; i < 8; i++) begin
      dec_req_i = mk(3'd0, 8'(64 + i + 1), 5'(i), 3'd0);
      #1;
      chk("t5_issued", 32'(sb_issued_o), 1);
      chk("t5_id", 32'(sb_req_o.insn_id), 32'(i));
      edge1;
    end
    dec_valid_i = 1'b0;
    #1;
    chk("t5_full_issued", 32'(sb_issued_o), 0);
    chk("t5_full_valid", 32'(vfu_valid_o), 0);
    chk("t5_full_ready", 32'(dec_ready_o), 0);
    edge1;
    chk("t5_hold_op", 32'(sb_req_o.op), 32'h48);
    insn_done_i       = 4'b0001;
    insn_done_id_i[0] = 3'd2;
    #1;
    chk("t5_free_same_cycle", 32'(sb_issued_o), 0);
    edge1;
    insn_done_i = '0;
    #1;
    chk("t5_reuse_issued", 32'(sb_issued_o), 1);
    chk("t5_reuse_id", 32'(sb_req_o.insn_id), 2);
    chk("t5_reuse_valid", 32'(vfu_valid_o), 32'b0001);
    edge1;

    // Fire takes ID 5 while IDs 0 and 3 complete in the same cycle
    insn_done_i       = 4'b0001;
    insn_done_id_i[0] = 3'd5;
    edge1;
    insn_done_i = '0;
    dec_valid_i = 1'b1;
    dec_req_i   = mk(3'd1, 8'h60, 5'd3, 3'd0);
    edge1;
    dec_valid_i       = 1'b0;
    insn_done_i       = 4'b0110;
    insn_done_id_i[1] = 3'd0;
    insn_done_id_i[2] = 3'd3;
    #1;
    chk("t6_issued", 32'(sb_issued_o), 1);
    chk("t6_id", 32'(sb_req_o.insn_id), 5);
    edge1;
    insn_done_i = '0;
    #1;
    chk("t6_bitmap", 32'(dut.u_id_alloc.busy_q), 32'b1111_0110);
    dec_valid_i = 1'b1;
    dec_req_i   = mk(3'd2, 8'h61, 5'd4, 3'd0);
    edge1;
    dec_req_i = mk(3'd3, 8'h62, 5'd6, 3'd0);
    #1;
    chk("t6_next_id0", 32'(sb_req_o.insn_id), 0);
    chk("t6_next_fire0", 32'(sb_issued_o), 1);
    edge1;
    dec_valid_i = 1'b0;
    #1;
    chk("t6_next_id3", 32'(sb_req_o.insn_id), 3);
    chk("t6_next_fire3", 32'(sb_issued_o), 1);
    edge1;
    chk("t6_not_idle", 32'(idle_o), 0);

    // Asynchronous reset with a request stuck on a full pool
    dec_valid_i = 1'b1;
    dec_req_i   = mk(3'd0, 8'h99, 5'd2, 3'd0);
    edge1;
    dec_valid_i = 1'b0;
    #1;
    chk("t7_held_ready", 32'(dec_ready_o), 0);
    rst_ni = 1'b0;
    #1;
    chk("t7_rst_idle", 32'(idle_o), 1);
    chk("t7_rst_ready", 32'(dec_ready_o), 1);
    chk("t7_rst_valid", 32'(vfu_valid_o), 0);
    edge1;
    rst_ni = 1'b1;
    #1;
    chk("t7_post_idle", 32'(idle_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/insn_launcher.md
# insn_launcher

Issue stage of the vector unit, directly upstream of `scoreboard`. Accepts decoded vector instructions one at a time into a single holding register. It assigns each a free instruction ID and presents the tagged request to the scoreboard for hazard checking. When there is no hazard and the target VFU is ready, it dispatches the instruction and pulses `is_issued` to the scoreboard. IDs are recycled on VFU completion.

## Interface
Parameters:
- `NrVFU`, default `core_pkg::NrVFU`: number of functional units.
- `InsnIDNum`, default `core_pkg::InsnIDNum`: number of in-flight instruction IDs.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `dec_valid_i`  in  1  decoded request valid.
- `dec_ready_o`  out  1  launcher can take a request.
- `dec_req_i`  in  `issue_req_t`  decoded request; `insn_id` field ignored.
- `sb_req_o`  out  `issue_req_t`  held request with assigned `insn_id`, to scoreboard `issue_req_i`.
- `sb_stall_i`  in  1  scoreboard `stall`.
- `sb_issued_o`  out  1  to scoreboard `is_issued_i`.
- `vfu_valid_o`  out  NrVFU  per-VFU dispatch valid.
- `vfu_ready_i`  in  NrVFU  per-VFU dispatch ready.
- `vfu_req_o`  out  `issue_req_t`  broadcast dispatch payload, equal to `sb_req_o`.
- `insn_done_i`  in  NrVFU  VFU completion strobe.
- `insn_done_id_i`  in  NrVFU x `insn_id_t`  completed ID.
- `idle_o`  out  1  no held request and all IDs free. Used for fences.

## Operation
- State:
  - `hold_valid_q`, `hold_req_q`: 1-entry buffer.
  - `id_busy_q[InsnIDNum]`: ID bitmap.
- ID selection: `free_id` is the lowest index with `id_busy_q == 0`. `id_avail` = any bit clear. `sb_req_o` is `hold_req_q` with `insn_id = free_id`.
- Target: `t = hold_req_q.vfu` (a `vfu_e` field of `issue_req_t`).
- `can_go = hold_valid_q & ~sb_stall_i & id_avail`.
- Dispatch: `vfu_valid_o[t] = can_go`. All other bits are 0. Valid never depends on `vfu_ready_i`.
- `fire = can_go & vfu_ready_i[t]`. `sb_issued_o = fire`.
- On `fire`: set `id_busy_d[free_id]`.
- For each i with `insn_done_i[i]`: clear `id_busy_d[insn_done_id_i[i]]`. Multiple VFUs may complete in the same cycle.
- A freed ID is selectable from the next cycle only, because selection uses `id_busy_q`.
- Buffer:
  - `dec_ready_o = ~hold_valid_q | fire`.
  - On `dec_valid_i & dec_ready_o`: load `hold_req_q`, set `hold_valid_q`.
  - Else if `fire`: clear `hold_valid_q`.
- Issue is strictly in order. A stalled head blocks all younger instructions.
- Once `vfu_valid_o[t]` is asserted, it may drop only because `sb_stall_i` rises. It may not drop because of a payload change: the payload is frozen while held.
- `idle_o = ~hold_valid_q & ~|id_busy_q`.

## Timing
- Reset values:
  - `hold_valid_q = 0`, `id_busy_q = 0`.
  - `dec_ready_o = 1`, `vfu_valid_o = 0`, `sb_issued_o = 0`, `idle_o = 1`.
  - `sb_req_o` and `vfu_req_o` are don't-care.
- Latency: accepted at cycle N, earliest `fire` at cycle N+1.
- Throughput: 1 instruction per cycle with no stall.
- Combinational paths:
  - `sb_req_o` → scoreboard `stall` → `sb_stall_i` → `fire` → `dec_ready_o`.
  - The scoreboard computes stall from registered state only, so there is no loop.
- Full ID pool: `id_avail = 0` means no valid and no fire. The request stays held. A completion in cycle N allows fire in N+1 at the earliest.
- Simultaneous fire and completion of different IDs are both applied in the same cycle.
- A completion of a non-busy ID is an assertion error.
- A hold of `vfu >= NrVFU` is an assertion error.
- Reset mid-operation drops the held request and frees all IDs immediately (asynchronous).

## Structure
- `core_pkg` owns:
  - `insn_id_t` and `InsnIDNum`.
  - `vfu_e` and `NrVFU`.
  - the `vfu` field added to `issue_req_t`.
- Sub-module `insn_id_alloc` holds the bitmap, lowest-free priority encoder, alloc/free ports and `all_free_o`. The launcher instantiates it once.

## Test plan
- Reset, then a single request to VFU 1 with no stall:
  - accepted at cycle 1; at cycle 2, `vfu_valid_o = 'b0010`, `sb_issued_o = 1`, `insn_id = 0`;
  - `idle_o = 0` until `insn_done_i[1]` with ID 0, then `idle_o = 1` the next cycle.
- 4 back-to-back requests with no stall and `vfu_ready_i` all 1 → `sb_issued_o` high for 4 consecutive cycles with IDs 0, 1, 2, 3, and `dec_ready_o` stays 1.
- `sb_stall_i = 1` for 5 cycles on a held request →
  - `vfu_valid_o = 0` and `dec_ready_o = 0` during the stall;
  - the payload is unchanged;
  - fire occurs in the first cycle after stall drops.
- `vfu_ready_i[t] = 0` for 3 cycles → `vfu_valid_o[t]` stays 1 with a stable payload and `sb_issued_o = 0`; fires in the cycle ready rises.
- Exhaust all `InsnIDNum` IDs → the next request holds. Complete ID 2 at cycle N → it issues at N+1 with `insn_id = 2`.
- Two VFUs complete IDs 0 and 3 in the same cycle as a fire takes ID 5 → the bitmap clears 0 and 3 and sets 5.
